tx_shift_ctrl: RTL
==================

// Module: tx_shift_ctrl
// PURPOSE
//  Transmit-side byte controller feeding the parallel-to-serial shift register (flex_pts_sr).
//  Accepts bytes over a valid/ready handshake into a one-entry holding buffer.
//  Drives the shift register's load_enable, shift_enable and parallel_in at a fixed bit rate.
//  Back-to-back bytes stream with no idle bit between them; the line idles high ('1 loaded) when no data.
// PARAMETERS
//  DATA_BITS     8  bits per byte; width of tx_data and parallel_out; must be >= 2
//  CLKS_PER_BIT  8  clock cycles per serial bit; must be >= 2
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  rst           in   1          synchronous active-high reset
//  tx_valid      in   1          upstream byte valid
//  tx_data       in   DATA_BITS  upstream byte
//  tx_ready      out  1          buffer can accept; transfer when tx_valid && tx_ready
//  load_enable   out  1          to shift register: load parallel_out this cycle
//  shift_enable  out  1          to shift register: advance one bit this cycle
//  parallel_out  out  DATA_BITS  to shift register parallel_in
//  tx_active     out  1          high while a byte is on the line (LOAD/SHIFT)
//  byte_done     out  1          one-cycle pulse in the final cycle of a byte's last bit
// BEHAVIOUR
//  Reset
//   - rst high: state=INIT, buf_full=0, bit_cnt=0, timer=0.
//   - Outputs during rst: tx_ready=0, load_enable=0, shift_enable=0, tx_active=0, byte_done=0, parallel_out='1.
//   - rst mid-byte: the in-flight byte and the buffered byte are dropped, with no byte_done.
//  State machine: INIT, IDLE, LOAD, SHIFT
//   - INIT (1 cycle after rst falls): load_enable=1, parallel_out='1, which forces the line high.
//     INIT always goes to IDLE.
//   - IDLE: stays in IDLE until buf_full=1, then goes to LOAD.
//   - LOAD (1 cycle):
//     - Drives load_enable=1 with parallel_out=buf, and clears buf_full.
//     - Sets bit_cnt=0 and timer=0, then goes to SHIFT.
//     - Bit 0 appears on serial_out in the following cycle.
//   - SHIFT: timer counts 0..CLKS_PER_BIT-1 and wraps to 0.
//     - At timer==CLKS_PER_BIT-1 with bit_cnt<DATA_BITS-1: shift_enable=1, bit_cnt++.
//     - At timer==CLKS_PER_BIT-1 with bit_cnt==DATA_BITS-1: byte_done=1, shift_enable=0, and then
//       - if buf_full: load_enable=1, parallel_out=buf, clear buf_full, bit_cnt=0; stay in SHIFT (zero-gap chaining).
//       - else: load_enable=1, parallel_out='1; go to IDLE.
//   - tx_active=1 in LOAD and SHIFT only.
//  Outputs
//   - load_enable and shift_enable are never high in the same cycle.
//   - parallel_out='1 in every cycle without a data load.
//  Handshake and buffer
//   - tx_ready = !buf_full && state!=INIT; it is a registered-state decode and has no combinational path from tx_valid.
//   - An accept sets buf_full and captures tx_data on the next edge.
//   - Accept and drain cannot coincide: drain requires full, accept requires empty.
//     tx_ready therefore rises the cycle after a drain.
//   - tx_data may change freely while tx_ready=0.
//  Timing
//   - Accept at edge N, from IDLE: LOAD in cycle N+1; bit 0 on the line for cycles N+2..N+1+CLKS_PER_BIT.
//   - Each byte occupies exactly DATA_BITS*CLKS_PER_BIT cycles of line time.
//   - Counters: bit_cnt width $clog2(DATA_BITS); timer width $clog2(CLKS_PER_BIT).
//     Comparisons use the full counter width.
// TESTING
//  1. Reset release -> one cycle load_enable=1 with parallel_out=8'hFF, then IDLE with tx_ready=1 and all strobes 0.
//  2. Single byte 8'hA5, CLKS_PER_BIT=8 -> LOAD 1 cycle after accept.
//     Expect 7 shift_enable pulses spaced 8 cycles apart, then byte_done plus load of 8'hFF; tx_active falls.
//  3. Back-to-back 8'h3C then 8'hC3, with the second accepted during the first byte ->
//     8'hC3 loads in the same cycle as the first byte_done; serial_out bit period is unbroken (128 cycles total).
//  4. tx_valid held with buffer full -> tx_ready=0 and the buffer is unchanged until the LOAD drain.
//     tx_ready=1 the next cycle.
//  5. rst asserted on the 3rd bit of a byte with a byte also buffered -> after release, INIT load of 8'hFF.
//     No byte_done and no further load of the dropped data.
//  6. Checker: load_enable && shift_enable never true; 16 random bytes received by a serial monitor in order (SHIFT_MSB=1).

Source files
------------

// File: rtl/tx_shift_ctrl_if.sv
// Upstream byte handshake into the transmit shift controller.
interface tx_shift_ctrl_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/tx_shift_ctrl.sv
// Transmit byte controller: one-entry holding buffer feeding a parallel-to-serial
// shift register through load/shift strobes at a fixed bit rate.
//
// state    | meaning
// ST_INIT  | first cycle after reset, loads all-ones to force the line high
// ST_IDLE  | line idle high, waiting for a buffered byte
// ST_LOAD  | loads the buffered byte into the shift register
// ST_SHIFT | byte on the line; shifts once per bit period, chains the next byte
module tx_shift_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_shift_ctrl_if.slave       up,
    output logic                 load_enable,
    output logic                 shift_enable,
    output logic [DATA_BITS-1:0] parallel_out,
    output logic                 tx_active,
    output logic                 byte_done
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 buf_full;
    logic                 buf_full_nxt;
    logic [DATA_BITS-1:0] hold_data;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_nxt;
    logic [TMR_W-1:0]     timer;
    logic [TMR_W-1:0]     timer_nxt;
    logic                 accept;

    // Pure decode of registered state: no path from tx_valid back to tx_ready.
    assign up.tx_ready = !rst && !buf_full && (state != ST_INIT);
    assign accept      = up.tx_valid && up.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            buf_full <= 1'b0;
            bit_cnt  <= '0;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            buf_full <= buf_full_nxt;
            bit_cnt  <= bit_cnt_nxt;
            timer    <= timer_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
        end else if (accept) begin
            hold_data <= up.tx_data;
        end
    end

    always_comb begin
        state_nxt    = state;
        buf_full_nxt = buf_full;
        bit_cnt_nxt  = bit_cnt;
        timer_nxt    = timer;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        parallel_out = '1;
        tx_active    = 1'b0;
        byte_done    = 1'b0;

        if (!rst) begin
            case (state)
                ST_INIT: begin
                    load_enable = 1'b1;
                    state_nxt   = ST_IDLE;
                end
                ST_IDLE: begin
                    if (buf_full) begin
                        state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_enable  = 1'b1;
                    parallel_out = hold_data;
                    tx_active    = 1'b1;
                    buf_full_nxt = 1'b0;
                    bit_cnt_nxt  = '0;
                    timer_nxt    = '0;
                    state_nxt    = ST_SHIFT;
                end
                ST_SHIFT: begin
                    tx_active = 1'b1;
                    if (timer == LAST_TICK) begin
                        timer_nxt = '0;
                        if (bit_cnt < LAST_BIT) begin
                            shift_enable = 1'b1;
                            bit_cnt_nxt  = bit_cnt + 1'b1;
                        end else begin
                            // Last bit ends: reload the line in the same cycle so
                            // a buffered byte follows with no idle bit.
                            byte_done   = 1'b1;
                            load_enable = 1'b1;
                            bit_cnt_nxt = '0;
                            if (buf_full) begin
                                parallel_out = hold_data;
                                buf_full_nxt = 1'b0;
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_INIT;
                end
            endcase

            // Accept needs an empty buffer and drain needs a full one, so they never collide.
            if (accept) begin
                buf_full_nxt = 1'b1;
            end
        end
    end

endmodule
